// File: rtl/cdc_fanout_pkg.sv
// rtl/cdc_fanout_pkg.sv - shared types and constants for the fan-out launcher
package cdc_fanout_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    LAUNCH    = 2'd1,
    WAIT_ACK  = 2'd2,
    WAIT_DROP = 2'd3
  } state_e;

  localparam int SYNC_DEPTH = 2;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - single-bit multi-flop synchronizer, async active-low reset to 0
module sync_2ff
  import cdc_fanout_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic q_o
);

  logic [SYNC_DEPTH-1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_DEPTH-2:0], d_i};
    end
  end

  assign q_o = sync_q[SYNC_DEPTH-1];

endmodule

// File: rtl/cdc_fanout_tx.sv
// rtl/cdc_fanout_tx.sv - broadcasts one word to N_DEST async domains over per-domain req/ack
// Optional handshake timeout enabled by defining CDC_FANOUT_TIMEOUT_EN.
module cdc_fanout_tx
  import cdc_fanout_pkg::*;
#(
  parameter int N_DEST         = 3,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              src_valid,
  output logic              src_ready,
  input  logic [DATA_W-1:0] src_data,
  input  logic [N_DEST-1:0] dest_en,
  output logic [DATA_W-1:0] data_o,
  output logic [N_DEST-1:0] req_o,
  input  logic [N_DEST-1:0] ack_i,
  output logic              done_o,
  output logic              err_o,
  input  logic              err_clr
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [N_DEST-1:0] mask_q, mask_d;
  logic [N_DEST-1:0] req_q, req_d;
  logic [N_DEST-1:0] ack_s, ack_m;
  logic              done_q, done_d;
  logic              accept, all_ack, none_ack, timeout, abort;

  for (genvar i = 0; i < N_DEST; i++) begin : g_sync
    sync_2ff u_sync (
      .clk  (clk),
      .rst_n(rst_n),
      .d_i  (ack_i[i]),
      .q_o  (ack_s[i])
    );
  end

  // Acks outside the captured mask never influence progress.
  assign ack_m     = ack_s & mask_q;
  assign all_ack   = (ack_m == mask_q);
  assign none_ack  = (ack_m == '0);
  assign src_ready = (state_q == IDLE);
  assign accept    = src_valid && src_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      mask_q  <= '0;
      req_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      mask_q  <= mask_d;
      req_q   <= req_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    abort   = 1'b0;
    unique case (state_q)
      IDLE:      if (accept) state_d = LAUNCH;
      LAUNCH:    state_d = (mask_q == '0) ? IDLE : WAIT_ACK;
      WAIT_ACK: begin
        if (all_ack) begin
          state_d = WAIT_DROP;
        end else if (timeout) begin
          state_d = IDLE;
          abort   = 1'b1;
        end
      end
      WAIT_DROP: begin
        if (none_ack) begin
          state_d = IDLE;
        end else if (timeout) begin
          state_d = IDLE;
          abort   = 1'b1;
        end
      end
      default:   state_d = IDLE;
    endcase
  end

  always_comb begin
    data_d = accept ? src_data : data_q;
    mask_d = accept ? dest_en  : mask_q;
    req_d  = req_q;
    if (state_q == LAUNCH) begin
      req_d = mask_q;
    end else if ((state_q == WAIT_ACK && all_ack) || abort) begin
      req_d = '0;
    end
    done_d = ((state_q == LAUNCH) && (mask_q == '0)) ||
             ((state_q == WAIT_DROP) && none_ack);
  end

  assign data_o = data_q;
  assign req_o  = req_q;
  assign done_o = done_q;

`ifdef CDC_FANOUT_TIMEOUT_EN
  logic [15:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  logic        waiting;

  assign waiting = (state_q == WAIT_ACK) || (state_q == WAIT_DROP);
  assign timeout = waiting && (cnt_q == 16'(TIMEOUT_CYCLES - 1));
  assign cnt_d   = (!waiting || (state_d != state_q)) ? 16'd0 : cnt_q + 16'd1;
  // A timeout in the same cycle as err_clr keeps the flag set.
  assign err_d   = abort ? 1'b1 : (err_clr ? 1'b0 : err_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign err_o = err_q;
`else
  localparam int UNUSED_TIMEOUT_CYCLES = TIMEOUT_CYCLES;
  logic unused_err_clr;

  assign unused_err_clr = err_clr;
  assign timeout        = 1'b0;
  assign err_o          = 1'b0;
`endif

endmodule

// File: tb/tb_cdc_fanout_tx.sv
// tb/tb_cdc_fanout_tx.sv - scoreboard bench for cdc_fanout_tx
module tb_cdc_fanout_tx;

  typedef struct {
    logic [7:0] data;
    logic [2:0] mask;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       src_valid = 1'b0;
  logic       src_ready;
  logic [7:0] src_data = 8'h00;
  logic [2:0] dest_en = 3'b000;
  logic [7:0] data_o;
  logic [2:0] req_o;
  logic [2:0] ack_i = 3'b000;
  logic       done_o;
  logic       err_o;
  logic       err_clr = 1'b0;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_fail = 0;
  int         n_done = 0;
  int         n_exp = 0;
  logic [2:0] req_seen = 3'b000;
  logic [2:0] ack_en = 3'b111;
  logic [2:0] noise_en = 3'b000;
  int         ack_cnt[3] = '{0, 0, 0};

  cdc_fanout_tx #(.N_DEST(3), .DATA_W(8), .TIMEOUT_CYCLES(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .src_valid(src_valid),
    .src_ready(src_ready),
    .src_data (src_data),
    .dest_en  (dest_en),
    .data_o   (data_o),
    .req_o    (req_o),
    .ack_i    (ack_i),
    .done_o   (done_o),
    .err_o    (err_o),
    .err_clr  (err_clr)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  // Destination model: follow req after 5 cycles, or toggle randomly when noisy.
  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (noise_en[i]) begin
        ack_i[i] = 1'($urandom_range(0, 1));
      end else if (!ack_en[i]) begin
        ack_i[i] = 1'b0;
        ack_cnt[i] = 0;
      end else if (req_o[i] != ack_i[i]) begin
        if (ack_cnt[i] >= 4) begin
          ack_i[i] = req_o[i];
          ack_cnt[i] = 0;
        end else begin
          ack_cnt[i]++;
        end
      end else begin
        ack_cnt[i] = 0;
      end
    end
  end

  // Monitor: req_o must only carry the pending mask; each done_o pops one entry.
  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      req_seen = 3'b000;
    end else begin
      if (req_o != 3'b000) begin
        req_seen = req_seen | req_o;
        if (sb_q.size() == 0) check("req_when_idle", 32'(req_o), 32'h0);
        else if (req_o != sb_q[0].mask) check("req_mask", 32'(req_o), 32'(sb_q[0].mask));
      end
      if (done_o) begin
        if (sb_q.size() == 0) begin
          check("done_unexpected", 32'(done_o), 32'h0);
        end else begin
          e = sb_q.pop_front();
          check("done_data", 32'(data_o), 32'(e.data));
          check("done_req_union", 32'(req_seen), 32'(e.mask));
          n_done++;
        end
        req_seen = 3'b000;
      end
    end
  end

  task automatic send(input logic [7:0] d, input logic [2:0] m, input bit expect_done);
    int k = 0;
    while (!src_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!src_ready) check("send_ready_timeout", 32'(src_ready), 32'h1);
    src_valid = 1'b1;
    src_data  = d;
    dest_en   = m;
    sb_q.push_back('{data: d, mask: m});
    if (expect_done) n_exp++;
    @(negedge clk);
    src_valid = 1'b0;
    src_data  = 8'hEE;
    dest_en   = 3'b111;
  endtask

  task automatic wait_done(input string name, output bit ready_hi);
    int k = 0;
    ready_hi = 1'b0;
    while (!done_o && k < 300) begin
      if (src_ready) ready_hi = 1'b1;
      @(negedge clk);
      k++;
    end
    if (!done_o) check({name, "_done_timeout"}, 32'(done_o), 32'h1);
  endtask

  task automatic wait_req(input string name, input logic [2:0] m);
    int k = 0;
    while (req_o != m && k < 50) begin
      @(negedge clk);
      k++;
    end
    check({name, "_req_up"}, 32'(req_o), 32'(m));
  endtask

  initial begin
    bit ready_hi;
    int k;
    repeat (3) @(negedge clk);
    check("rst_src_ready", 32'(src_ready), 32'h1);
    check("rst_req", 32'(req_o), 32'h0);
    check("rst_data", 32'(data_o), 32'h0);
    check("rst_done", 32'(done_o), 32'h0);
    check("rst_err", 32'(err_o), 32'h0);
    rst_n = 1'b1;
    @(negedge clk);

    // Full broadcast: data settles one cycle before req rises.
    send(8'hA5, 3'b111, 1'b1);
    check("all_data_before_req", 32'(data_o), 32'hA5);
    check("all_req_still_low", 32'(req_o), 32'h0);
    @(negedge clk);
    check("all_req_up", 32'(req_o), 32'h7);
    wait_done("all", ready_hi);
    check("all_ready_low_busy", 32'(ready_hi), 32'h0);
    @(negedge clk);

    // Empty mask: done two cycles after the accept cycle.
    send(8'h3C, 3'b000, 1'b1);
    check("empty_data", 32'(data_o), 32'h3C);
    check("empty_done_early", 32'(done_o), 32'h0);
    @(negedge clk);
    check("empty_done", 32'(done_o), 32'h1);
    check("empty_req", 32'(req_o), 32'h0);
    @(negedge clk);

    // Partial mask with noise on unmasked acks.
    ack_en = 3'b000;
    noise_en = 3'b101;
    send(8'h77, 3'b010, 1'b1);
    wait_req("part", 3'b010);
    k = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_o) k++;
    end
    check("part_no_done_without_ack1", 32'(k), 32'h0);
    check("part_req_held", 32'(req_o), 32'h2);
    ack_en = 3'b010;
    wait_done("part", ready_hi);
    noise_en = 3'b000;
    ack_en = 3'b111;
    repeat (3) @(negedge clk);

    // Back-to-back accept in the done cycle.
    send(8'h11, 3'b111, 1'b1);
    wait_done("b2b_first", ready_hi);
    check("b2b_data_held", 32'(data_o), 32'h11);
    check("b2b_acks_dropped", 32'(ack_i), 32'h0);
    check("b2b_ready_in_done", 32'(src_ready), 32'h1);
    send(8'h22, 3'b101, 1'b1);
    check("b2b_second_data", 32'(data_o), 32'h22);
    wait_done("b2b_second", ready_hi);
    @(negedge clk);

    // Reset during WAIT_ACK.
    ack_en = 3'b000;
    send(8'h5A, 3'b111, 1'b0);
    wait_req("rst_mid", 3'b111);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("rst_mid_req", 32'(req_o), 32'h0);
    check("rst_mid_data", 32'(data_o), 32'h0);
    check("rst_mid_ready", 32'(src_ready), 32'h1);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    k = 0;
    repeat (10) begin
      @(negedge clk);
      if (done_o) k++;
    end
    check("rst_mid_no_done", 32'(k), 32'h0);
    check("rst_mid_ready_after", 32'(src_ready), 32'h1);

`ifdef CDC_FANOUT_TIMEOUT_EN
    // Timeout: ack held low, req stays up for exactly 16 WAIT_ACK cycles.
    send(8'h99, 3'b001, 1'b0);
    wait_req("to", 3'b001);
    k = 0;
    while (req_o != 3'b000 && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("to_req_cycles", 32'(k), 32'd16);
    check("to_err", 32'(err_o), 32'h1);
    check("to_req_low", 32'(req_o), 32'h0);
    check("to_ready", 32'(src_ready), 32'h1);
    sb_q.delete();
    err_clr = 1'b1;
    @(negedge clk);
    err_clr = 1'b0;
    check("to_err_clr", 32'(err_o), 32'h0);
`endif
    ack_en = 3'b111;

    repeat (5) @(negedge clk);
    check("sb_empty", 32'(sb_q.size()), 32'h0);
    check("done_count", 32'(n_done), 32'(n_exp));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end, required finish before 200000 ns");
    $fatal(1);
  end

endmodule
